pixel_frame_ctrl: RTL
=====================

# pixel_frame_ctrl

Frame sequencer for the pixel array. Drives the erase/expose/convert/read0/read1 phase strobes with a programmable exposure length, generates the digital ramp code used during conversion, and packs the two 8-bit column buses from the two readout rows into one 32-bit word. The word is delivered downstream over a valid/ready handshake. The block sits between the array and the readout logic, replacing free-running phase stepping with back-pressure-aware sequencing.

## Interface
Parameters:
- EXPOSE_W, 8: width of the exposure-length input.
- ERASE_CYC, 4: number of cycles `erase` is held high (≥1).
- CONV_MAX, 255: final ramp code. CONVERT lasts CONV_MAX+1 cycles; CONV_MAX ≤ 255.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- continuous  in  1  when 1, frames repeat back-to-back without needing `start`
- expose_len  in  EXPOSE_W  exposure cycles; latched on leaving IDLE/OUT
- erase, expose, convert, read0, read1  out  1 each  one-hot phase strobes to the array
- ramp_code  out  8  ramp/ADC code, counts during CONVERT
- col_data0, col_data1  in  8 each  array column outputs
- data_out  out  32  packed frame word
- data_valid  out  1  data_out holds a valid word
- data_ready  in  1  consumer accepts the word
- busy  out  1  high in every state except IDLE
- frame_cnt  out  8  present only with PIXEL_CTRL_FRAME_CNT_EN

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ0, READ1, OUT. Registered Moore outputs. At most one phase strobe is high in any cycle.
- IDLE: all strobes 0. If start=1 or continuous=1, go to ERASE and latch expose_len into elen.
- ERASE: erase=1 for ERASE_CYC cycles, then go to EXPOSE.
- EXPOSE: expose=1 for elen cycles, then go to CONVERT. If elen=0, the block treats it as 1.
- CONVERT: convert=1. ramp_code counts 0,1,…,CONV_MAX, one step per cycle, then the block goes to READ0. ramp_code is 0 in all other states.
- READ0: read0=1 for one cycle. On the closing edge, the block captures data_out[7:0]←col_data0 and data_out[15:8]←col_data1.
- READ1: read1=1 for one cycle. On the closing edge, the block captures data_out[23:16]←col_data0 and data_out[31:24]←col_data1.
- OUT: data_valid=1 and data_out is held stable. When data_valid&&data_ready:
  - if continuous=1, go to ERASE (re-latching expose_len);
  - otherwise go to IDLE.
- data_out keeps its last value until the next READ0 capture.
- Ignored inputs:
  - start outside IDLE is ignored; it is not queued.
  - Dropping continuous mid-frame does not abort the frame. The value seen in OUT decides the next state.
  - Changing expose_len mid-frame has no effect until the next latch.
- busy=1 in ERASE through OUT.

## Timing
- Reset (async, immediate): state IDLE; all strobes, ramp_code, data_out, data_valid, busy and frame_cnt = 0. Reset mid-frame discards the partial word.
- Latency: with start sampled at edge 0, the block is in ERASE after edge 0. data_valid first goes high after edge ERASE_CYC + elen + CONV_MAX + 1 + 2.
  - Defaults with elen=10: high after edge 272.
- data_ready=1 continuously: OUT lasts exactly 1 cycle. Continuous-mode frame period = ERASE_CYC + elen + CONV_MAX + 4 cycles (273 with the defaults above).
- data_ready held low: the block stalls in OUT indefinitely. No strobe is asserted, and data_out and data_valid do not change.
- Column inputs must be stable during the READ0/READ1 cycle. There is no setup assumption beyond one clk period.

## Configuration
- PIXEL_CTRL_FRAME_CNT_EN defined:
  - frame_cnt port exists.
  - It increments by 1 on each accepted handshake (valid&&ready) and wraps 255→0.
  - It is reset to 0.
- Not defined: no frame_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Single frame, defaults, expose_len=10, col_data0/1 driven 0x11/0x22 in READ0 and 0x33/0x44 in READ1, data_ready=1 → data_out=0x44332211 with data_valid high for 1 cycle after edge 272, then IDLE, busy=0.
- Strobe check over one frame → erase high exactly 4 cycles, expose 10, convert 256 with ramp_code 0..255 monotonic, read0/read1 one cycle each. The strobes are never simultaneously high.
- Back-pressure: data_ready=0 for 50 cycles in OUT → data_valid stays 1, data_out is unchanged, no strobes. Raising ready → one transfer, then IDLE.
- Continuous=1 with ready tied high → frames start every 273 cycles. Clearing continuous mid-CONVERT → the current frame completes, then IDLE.
- expose_len=0 → EXPOSE lasts 1 cycle. start pulsed during EXPOSE → ignored, only one word produced.
- Reset asserted mid-CONVERT → all outputs 0 immediately. After release, a new start produces a correct frame. With PIXEL_CTRL_FRAME_CNT_EN, 257 accepted words → frame_cnt=1.

Source files
------------

// File: rtl/pixel_frame_ctrl.sv
// Frame phase sequencer: erase/expose/convert/read strobes, ramp code, 32-bit readout packer.
// Optional frame counter port/logic enabled by defining PIXEL_CTRL_FRAME_CNT_EN.
module pixel_frame_ctrl #(
  parameter int EXPOSE_W  = 8,
  parameter int ERASE_CYC = 4,
  parameter int CONV_MAX  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic [EXPOSE_W-1:0] expose_len,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic                read0,
  output logic                read1,
  output logic [7:0]          ramp_code,
  input  logic [7:0]          col_data0,
  input  logic [7:0]          col_data1,
  output logic [31:0]         data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                busy
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  ,
  output logic [7:0]          frame_cnt
`endif
);

  localparam int ER_W  = $clog2(ERASE_CYC + 1);
  localparam int CNT_W = (EXPOSE_W > ER_W) ? EXPOSE_W : ER_W;

  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYC - 1);
  localparam logic [7:0]       RAMP_END   = 8'(CONV_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ0,
    S_READ1,
    S_OUT
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [EXPOSE_W-1:0] r_elen;
  logic [7:0]          r_ramp;
  logic [31:0]         r_data;
  logic                r_erase;
  logic                r_expose;
  logic                r_convert;
  logic                r_read0;
  logic                r_read1;
  logic                r_valid;
  logic                r_busy;

  // Strobes default low each cycle; each transition raises the one for the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_elen    <= '0;
      r_ramp    <= '0;
      r_data    <= '0;
      r_erase   <= 1'b0;
      r_expose  <= 1'b0;
      r_convert <= 1'b0;
      r_read0   <= 1'b0;
      r_read1   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_erase   <= 1'b0;
      r_expose  <= 1'b0;
      r_convert <= 1'b0;
      r_read0   <= 1'b0;
      r_read1   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start || continuous) begin
            r_state <= S_ERASE;
            r_elen  <= expose_len;
            r_cnt   <= ERASE_LAST;
            r_erase <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ERASE: begin
          if (r_cnt == '0) begin
            r_state  <= S_EXPOSE;
            r_expose <= 1'b1;
            // A zero exposure length still spends one cycle in EXPOSE.
            r_cnt    <= (r_elen == '0) ? '0
                      : CNT_W'(r_elen - EXPOSE_W'(1));
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_erase <= 1'b1;
          end
        end
        S_EXPOSE: begin
          if (r_cnt == '0) begin
            r_state   <= S_CONVERT;
            r_convert <= 1'b1;
            r_ramp    <= '0;
          end else begin
            r_cnt    <= r_cnt - CNT_W'(1);
            r_expose <= 1'b1;
          end
        end
        S_CONVERT: begin
          if (r_ramp == RAMP_END) begin
            r_state <= S_READ0;
            r_read0 <= 1'b1;
            r_ramp  <= '0;
          end else begin
            r_ramp    <= r_ramp + 8'd1;
            r_convert <= 1'b1;
          end
        end
        S_READ0: begin
          r_data[15:0] <= {col_data1, col_data0};
          r_state      <= S_READ1;
          r_read1      <= 1'b1;
        end
        S_READ1: begin
          r_data[31:16] <= {col_data1, col_data0};
          r_state       <= S_OUT;
          r_valid       <= 1'b1;
        end
        S_OUT: begin
          if (data_ready) begin
            r_valid <= 1'b0;
            if (continuous) begin
              r_state <= S_ERASE;
              r_elen  <= expose_len;
              r_cnt   <= ERASE_LAST;
              r_erase <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIXEL_CTRL_FRAME_CNT_EN
  logic       w_accept;
  logic [7:0] r_frame_cnt;

  assign w_accept = (r_state == S_OUT) && r_valid && data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_accept) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign erase      = r_erase;
  assign expose     = r_expose;
  assign convert    = r_convert;
  assign read0      = r_read0;
  assign read1      = r_read1;
  assign ramp_code  = r_ramp;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign busy       = r_busy;

endmodule
